// File: rtl/isa_pkg.sv
// isa_pkg: opcodes, instruction-class tags and field positions shared by fetch/decode and register-read
package isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic [1:0] {
        ITYPE_R   = 2'b00,
        ITYPE_I   = 2'b01,
        ITYPE_J   = 2'b10,
        ITYPE_BAD = 2'b11
    } itype_t;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SHAMT_HI  = 10;
    localparam int SHAMT_LO  = 6;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;

    function automatic itype_t decode_itype(input logic [5:0] op);
        return (op == OP_RTYPE) ? ITYPE_R :
               (op == OP_J || op == OP_JAL) ? ITYPE_J :
               (op == OP_LW || op == OP_SW || op == OP_ADDI || op == OP_BEQ) ? ITYPE_I :
               ITYPE_BAD;
    endfunction

endpackage

// File: rtl/imem_sync.sv
// imem_sync: instruction memory with synchronous write and combinational read (read-before-write at the edge)
module imem_sync #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // write on the edge; a same-edge register of rdata still captures the old word
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/ifetch_decode.sv
// ifetch_decode: PC-driven fetch from local imem into an IR, with field split, stall, redirect bubble and counters
module ifetch_decode
    import isa_pkg::*;
#(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pc_load,
    input  logic [31:0]      pc_target,
    input  logic             imem_we,
    input  logic [31:0]      imem_waddr,
    input  logic [31:0]      imem_wdata,
    output logic             instr_valid,
    output logic [31:0]      pc_out,
    output logic [31:0]      instr,
    output logic [5:0]       OpCode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [15:0]      imm,
    output logic [1:0]       itype,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic {FETCH, BUBBLE} state_t;

    state_t      state, state_nx;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{imem_waddr[31:AW+2], imem_waddr[1:0]};

    imem_sync #(.DEPTH(IMEM_DEPTH), .AW(AW)) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (imem_waddr[AW+1:2]),
        .wdata (imem_wdata),
        .raddr (pc[AW+1:2]),
        .rdata (rdata)
    );

    // fetch state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= FETCH;
        else       state <= state_nx;

    // a redirect forces one bubble cycle, a stall freezes the state, otherwise keep fetching
    always_comb begin
        state_nx = state;
        state_nx = pc_load ? BUBBLE : stall ? state : FETCH;
    end

    // PC, IR and status registers; priority is redirect over stall over fetch
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pc           <= RESET_PC;
            instr        <= '0;
            pc_out       <= '0;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else if (pc_load) begin
            pc          <= {pc_target[31:2], 2'b00};
            instr       <= '0;
            instr_valid <= 1'b0;
            if (|pc_target[1:0]) misalign_err <= 1'b1;
        end else if (!stall) begin
            instr       <= rdata;
            pc_out      <= pc;
            pc          <= pc + 32'd4;
            instr_valid <= 1'b1;
            if (~&fetch_count) fetch_count <= fetch_count + 1'b1;
        end

    assign OpCode = instr[OPCODE_HI:OPCODE_LO];
    assign rs     = instr[RS_HI:RS_LO];
    assign rt     = instr[RT_HI:RT_LO];
    assign rd     = instr[RD_HI:RD_LO];
    assign shamt  = instr[SHAMT_HI:SHAMT_LO];
    assign funct  = instr[FUNCT_HI:FUNCT_LO];
    assign imm    = instr[IMM_HI:IMM_LO];
    assign itype  = decode_itype(OpCode);

endmodule

// File: tb/tb_ifetch_decode.sv
// tb_ifetch_decode: directed vector table plus hand sequences for redirect, wrap, write collision and async reset
module tb_ifetch_decode;

    logic        clk, reset, stall, pc_load, imem_we;
    logic [31:0] pc_target, imem_waddr, imem_wdata;
    logic        instr_valid, misalign_err;
    logic [31:0] pc_out, instr;
    logic [5:0]  OpCode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [1:0]  itype;
    logic [15:0] fetch_count;

    int total = 0;
    int bad   = 0;

    ifetch_decode #(.IMEM_DEPTH(64), .RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .instr_valid  (instr_valid),
        .pc_out       (pc_out),
        .instr        (instr),
        .OpCode       (OpCode),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .shamt        (shamt),
        .funct        (funct),
        .imm          (imm),
        .itype        (itype),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        ld;
        logic [31:0] tgt;
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        int          cnt;
        logic [1:0]  it;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        imem_we = 1'b1;
        imem_waddr = a;
        imem_wdata = d;
        step();
        imem_we = 1'b0;
    endtask

    task automatic chk_clear(input string tag);
        chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, ".pc_out"}, pc_out, 32'd0);
        chk({tag, ".instr"}, instr, 32'd0);
        chk({tag, ".count"}, {16'd0, fetch_count}, 32'd0);
        chk({tag, ".misalign"}, {31'd0, misalign_err}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'd0,  32'h8C620005, 1,  2'b01};
        vecs[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'd4,  32'hAC690007, 2,  2'b01};
        vecs[2]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'd4,  32'hAC690007, 2,  2'b01};
        vecs[3]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'd4,  32'hAC690007, 2,  2'b01};
        vecs[4]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'd4,  32'hAC690007, 2,  2'b01};
        vecs[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'd8,  32'h8D470000, 3,  2'b01};
        vecs[6]  = '{1'b0, 1'b1, 32'h4, 1'b0, 32'd8,  32'h00000000, 3,  2'b00};
        vecs[7]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'd4,  32'hAC690007, 4,  2'b01};
        vecs[8]  = '{1'b1, 1'b1, 32'h4, 1'b0, 32'd4,  32'h00000000, 4,  2'b00};
        vecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'd4,  32'hAC690007, 5,  2'b01};
        vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'd8,  32'h8D470000, 6,  2'b01};
        vecs[11] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'd12, 32'h012A4020, 7,  2'b00};
        vecs[12] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'd16, 32'h08000010, 8,  2'b10};
        vecs[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'd20, 32'h20420001, 9,  2'b01};
        vecs[14] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'd24, 32'hFC000000, 10, 2'b11};

        reset = 1'b1;
        stall = 1'b1;
        pc_load = 1'b0;
        pc_target = '0;
        imem_we = 1'b0;
        imem_waddr = '0;
        imem_wdata = '0;
        step();
        step();
        chk_clear("reset");
        reset = 1'b0;
        wr(32'd0,  32'h8C620005);
        wr(32'd4,  32'hAC690007);
        wr(32'd8,  32'h8D470000);
        wr(32'd12, 32'h012A4020);
        wr(32'd16, 32'h08000010);
        wr(32'd20, 32'h20420001);
        wr(32'd24, 32'hFC000000);
        chk("stalled.valid", {31'd0, instr_valid}, 32'd0);
        chk("stalled.count", {16'd0, fetch_count}, 32'd0);

        for (int i = 0; i < 15; i++) begin
            stall = vecs[i].st;
            pc_load = vecs[i].ld;
            pc_target = vecs[i].tgt;
            step();
            chk($sformatf("v%0d.valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].v});
            chk($sformatf("v%0d.pc_out", i), pc_out, vecs[i].pc);
            chk($sformatf("v%0d.instr", i), instr, vecs[i].ins);
            chk($sformatf("v%0d.opcode", i), {26'd0, OpCode}, {26'd0, vecs[i].ins[31:26]});
            chk($sformatf("v%0d.rs", i), {27'd0, rs}, {27'd0, vecs[i].ins[25:21]});
            chk($sformatf("v%0d.rt", i), {27'd0, rt}, {27'd0, vecs[i].ins[20:16]});
            chk($sformatf("v%0d.rd", i), {27'd0, rd}, {27'd0, vecs[i].ins[15:11]});
            chk($sformatf("v%0d.shamt", i), {27'd0, shamt}, {27'd0, vecs[i].ins[10:6]});
            chk($sformatf("v%0d.funct", i), {26'd0, funct}, {26'd0, vecs[i].ins[5:0]});
            chk($sformatf("v%0d.imm", i), {16'd0, imm}, {16'd0, vecs[i].ins[15:0]});
            chk($sformatf("v%0d.itype", i), {30'd0, itype}, {30'd0, vecs[i].it});
            chk($sformatf("v%0d.count", i), {16'd0, fetch_count}, vecs[i].cnt);
            if (i == 0) begin
                chk("first.rs", {27'd0, rs}, 32'd3);
                chk("first.rt", {27'd0, rt}, 32'd2);
                chk("first.imm", {16'd0, imm}, 32'd5);
            end
        end
        pc_load = 1'b0;
        stall = 1'b0;

        chk("misalign.pre", {31'd0, misalign_err}, 32'd0);
        pc_load = 1'b1;
        pc_target = 32'h0000_0102;
        step();
        pc_load = 1'b0;
        chk("misalign.set", {31'd0, misalign_err}, 32'd1);
        chk("misalign.bubble", {31'd0, instr_valid}, 32'd0);
        step();
        chk("wrap.pc_out", pc_out, 32'h0000_0100);
        chk("wrap.instr", instr, 32'h8C620005);
        step();
        chk("wrap.next", instr, 32'hAC690007);
        chk("misalign.sticky", {31'd0, misalign_err}, 32'd1);

        imem_we = 1'b1;
        imem_waddr = 32'd8;
        imem_wdata = 32'h2108FFFF;
        step();
        imem_we = 1'b0;
        chk("rbw.old", instr, 32'h8D470000);
        chk("rbw.pc_out", pc_out, 32'h0000_0108);
        pc_load = 1'b1;
        pc_target = 32'd8;
        step();
        pc_load = 1'b0;
        step();
        chk("rbw.new", instr, 32'h2108FFFF);
        stall = 1'b1;
        wr(32'd8, 32'h8D470000);
        stall = 1'b0;

        pc_load = 1'b1;
        pc_target = 32'd0;
        step();
        pc_load = 1'b0;
        step();
        step();
        chk("pre_reset.pc_out", pc_out, 32'd4);
        #2;
        reset = 1'b1;
        #1;
        chk_clear("async_reset");
        step();
        reset = 1'b0;
        step();
        chk("after_reset.pc_out", pc_out, 32'd0);
        chk("after_reset.instr", instr, 32'h8C620005);
        chk("after_reset.count", {16'd0, fetch_count}, 32'd1);
        chk("after_reset.misalign", {31'd0, misalign_err}, 32'd0);
        step();
        step();
        chk("after_reset.mem8", instr, 32'h8D470000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
